// File: rtl/vector_load_unit_if.sv
// Bundle between the vector load unit, its data memory read port and the
// vector register bank write port, plus the load command/status signals.
interface vector_load_unit_if #(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int AW = 32
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic [1:0]    dst;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [N-1:0]  mem_rdata;
  logic          vwe;
  logic [1:0]    vwa;
  logic [V-1:0]  vwd;

  modport master (
    input  start, base_addr, stride, dst, mem_gnt, mem_rvalid, mem_rdata,
    output busy, done, err, mem_req, mem_addr, vwe, vwa, vwd
  );

  modport slave (
    output start, base_addr, stride, dst, mem_gnt, mem_rvalid, mem_rdata,
    input  busy, done, err, mem_req, mem_addr, vwe, vwa, vwd
  );
endinterface

// File: rtl/vector_load_unit.sv
// Strided vector gather: L single-word reads, one outstanding request at a time,
// assembled into a V-bit vector and written to the register bank in one cycle.
module vector_load_unit #(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int AW = 32
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  vector_load_unit_if.master  bus
);
  localparam int L  = V / N;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] stride_q;
  logic [1:0]    dst_q;
  logic [LW-1:0] lane_q;
  logic [V-1:0]  lane_buf_q;
  logic [V-1:0]  lane_buf_d;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          mem_req_q;
  logic          vwe_q;
  logic [1:0]    vwa_q;
  logic [V-1:0]  vwd_q;
  logic          aligned_s;

  assign aligned_s = (bus.base_addr[1:0] == 2'b00) && (bus.stride[1:0] == 2'b00);

  // Merge the returning word into its lane slot; other lanes keep their contents.
  always_comb begin
    lane_buf_d = lane_buf_q;
    for (int i = 0; i < L; i++) begin
      if ((state_q == S_WAIT) && bus.mem_rvalid && (lane_q == LW'(i))) begin
        lane_buf_d[i*N +: N] = bus.mem_rdata;
      end else begin
        lane_buf_d[i*N +: N] = lane_buf_q[i*N +: N];
      end
    end
  end

  // Load sequencer with all status and bus outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      dst_q      <= 2'd0;
      lane_q     <= '0;
      lane_buf_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      vwe_q      <= 1'b0;
      vwa_q      <= 2'd0;
      vwd_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vwe_q      <= 1'b0;
      lane_buf_q <= lane_buf_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start && aligned_s) begin
            addr_q    <= bus.base_addr;
            stride_q  <= bus.stride;
            dst_q     <= bus.dst;
            lane_q    <= '0;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            state_q   <= S_ISSUE;
          end else if (bus.start) begin
            // Misaligned command: report and drop it without touching memory.
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        S_ISSUE: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            addr_q <= addr_q + stride_q;
            if (lane_q == LANE_LAST) begin
              vwe_q   <= 1'b1;
              done_q  <= 1'b1;
              vwa_q   <= dst_q;
              vwd_q   <= lane_buf_d;
              state_q <= S_WRITE;
            end else begin
              lane_q    <= lane_q + LW'(1);
              mem_req_q <= 1'b1;
              state_q   <= S_ISSUE;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WRITE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = addr_q;
  assign bus.vwe      = vwe_q;
  assign bus.vwa      = vwa_q;
  assign bus.vwd      = vwd_q;
endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench: a memory responder with programmable grant/data delays
// drives the unit; results are compared against an address/data/latency model.
module tb_vector_load_unit;
  localparam int V  = 128;
  localparam int N  = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vector_load_unit_if #(.V(V), .N(N), .AW(AW)) bus ();

  vector_load_unit #(.V(V), .N(N), .AW(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0]  lane_data [4];
  logic [31:0]  obs_addrs [$];
  int           obs_unstable, obs_vwe_cnt, obs_vwe_cyc, obs_done_bad;
  int           obs_err_cnt, obs_err_cyc, obs_busy_cnt, obs_req_cnt;
  logic [1:0]   obs_vwa;
  logic [127:0] obs_vwd;
  logic         obs_pre_busy;
  logic [4:0]   rst_flags;
  logic [31:0]  rst_addr;
  logic [1:0]   rst_vwa;
  logic [127:0] rst_vwd;

  function automatic logic [127:0] model_vector();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = lane_data[i];
    return v;
  endfunction

  function automatic int model_cycle(input int gd, input int rd);
    return 1 + 4 * (gd + rd + 2);
  endfunction

  // Issue one command at the next edge and act as memory for ncyc cycles.
  task automatic run_op(input logic [31:0] base, input logic [31:0] strd, input logic [1:0] dst,
                        input int gd, input int rd, input bit noise,
                        input int again_cyc, input int abort_cyc, input int ncyc);
    int req_wait = 0;
    int rv_cnt = -1;
    int lane = 0;
    logic in_req = 1'b0;
    logic [31:0] held = 32'd0;
    obs_addrs.delete();
    obs_unstable = 0; obs_vwe_cnt = 0; obs_vwe_cyc = -1; obs_done_bad = 0;
    obs_err_cnt = 0; obs_err_cyc = -1; obs_busy_cnt = 0; obs_req_cnt = 0;
    @(negedge clk);
    obs_pre_busy  = bus.busy;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.stride    = strd;
    bus.dst       = dst;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      rst_n          = 1'b1;
      bus.start      = (c == again_cyc);
      bus.base_addr  = (c == again_cyc) ? 32'h0000_0800 : base;
      bus.dst        = (c == again_cyc) ? ~dst : dst;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (c == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        rst_flags = {bus.busy, bus.done, bus.err, bus.mem_req, bus.vwe};
        rst_addr  = bus.mem_addr;
        rst_vwa   = bus.vwa;
        rst_vwd   = bus.vwd;
        in_req    = 1'b0;
        rv_cnt    = -1;
        continue;
      end
      if (bus.busy) obs_busy_cnt++;
      if (bus.err) begin obs_err_cnt++; obs_err_cyc = c; end
      if (bus.done !== bus.vwe) obs_done_bad++;
      if (bus.vwe) begin obs_vwe_cnt++; obs_vwe_cyc = c; obs_vwa = bus.vwa; obs_vwd = bus.vwd; end
      if (bus.mem_req) begin
        obs_req_cnt++;
        if (!in_req) begin
          in_req = 1'b1; req_wait = 0; held = bus.mem_addr; obs_addrs.push_back(bus.mem_addr);
        end else if (bus.mem_addr !== held) begin
          obs_unstable++;
        end
        if (req_wait == gd) begin
          bus.mem_gnt = 1'b1; in_req = 1'b0; rv_cnt = rd;
        end else begin
          req_wait++;
          if (noise) bus.mem_rvalid = 1'b1;
        end
      end else if (rv_cnt >= 0) begin
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = lane_data[lane % 4]; lane++; rv_cnt = -1;
        end else begin
          rv_cnt--;
          if (noise) bus.mem_gnt = 1'b1;
        end
      end else if (noise) begin
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = 32'd0; bus.stride = 32'd0; bus.dst = 2'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.busy, bus.done, bus.err, bus.mem_req, bus.vwe} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got %b want 00000", {bus.busy, bus.done, bus.err, bus.mem_req, bus.vwe}); end
    checks++; if (bus.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.vwa !== 2'd0) begin errors++; $display("FAIL reset_vwa got %0d want 0", bus.vwa); end
    checks++; if (bus.vwd !== 128'd0) begin errors++; $display("FAIL reset_vwd got %h want 0", bus.vwd); end
    rst_n = 1'b1;
  endtask

  task automatic test_contiguous();
    lane_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    run_op(32'h100, 32'd4, 2'd2, 0, 0, 1'b0, 0, 0, 10);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a = 32'h100 + 32'(i) * 32'd4;
      logic [31:0] got_a = (i < obs_addrs.size()) ? obs_addrs[i] : 32'hxxxx_xxxx;
      checks++; if (got_a !== exp_a) begin errors++; $display("FAIL contig_addr%0d got %h want %h", i, got_a, exp_a); end
    end
    checks++; if (obs_vwe_cyc !== 9 || obs_vwe_cnt !== 1) begin errors++;
      $display("FAIL contig_vwe got cyc %0d cnt %0d want cyc 9 cnt 1", obs_vwe_cyc, obs_vwe_cnt); end
    checks++; if (obs_vwa !== 2'd2) begin errors++; $display("FAIL contig_vwa got %0d want 2", obs_vwa); end
    checks++; if (obs_vwd !== 128'h44444444_33333333_22222222_11111111) begin errors++;
      $display("FAIL contig_vwd got %h want 44444444333333332222222211111111", obs_vwd); end
    checks++; if (obs_done_bad !== 0) begin errors++; $display("FAIL contig_done got %0d bad cycles want 0", obs_done_bad); end
    checks++; if (obs_busy_cnt !== 9) begin errors++; $display("FAIL contig_busy got %0d cycles want 9", obs_busy_cnt); end
  endtask

  task automatic test_strided_backpressure();
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h40, 32'h20, 2'd1, 2, 0, 1'b1, 0, 0, 18);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a = 32'h40 + 32'(i) * 32'h20;
      logic [31:0] got_a = (i < obs_addrs.size()) ? obs_addrs[i] : 32'hxxxx_xxxx;
      checks++; if (got_a !== exp_a) begin errors++; $display("FAIL stride_addr%0d got %h want %h", i, got_a, exp_a); end
    end
    checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL stride_hold got %0d changes want 0", obs_unstable); end
    checks++; if (obs_vwe_cyc !== 17) begin errors++; $display("FAIL stride_vwe_cycle got %0d want 17", obs_vwe_cyc); end
    checks++; if (obs_vwd !== model_vector()) begin errors++; $display("FAIL stride_vwd got %h want %h", obs_vwd, model_vector()); end
    checks++; if (obs_req_cnt !== 12) begin errors++; $display("FAIL stride_req_cycles got %0d want 12", obs_req_cnt); end
  endtask

  task automatic test_misaligned();
    logic [31:0] bases [3] = '{32'h102, 32'h100, 32'h201};
    logic [31:0] strds [3] = '{32'd4, 32'd6, 32'd8};
    for (int k = 0; k < 3; k++) begin
      run_op(bases[k], strds[k], 2'd3, 0, 0, 1'b0, 0, 0, 4);
      checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== 1) begin errors++;
        $display("FAIL misalign%0d_err got cnt %0d cyc %0d want cnt 1 cyc 1", k, obs_err_cnt, obs_err_cyc); end
      checks++; if (obs_busy_cnt !== 0 || obs_req_cnt !== 0 || obs_vwe_cnt !== 0) begin errors++;
        $display("FAIL misalign%0d_quiet got busy %0d req %0d vwe %0d want 0 0 0", k, obs_busy_cnt, obs_req_cnt, obs_vwe_cnt); end
    end
    // An aligned start two edges after a rejected one must be accepted.
    run_op(32'h300, 32'h5, 2'd0, 0, 0, 1'b0, 0, 0, 1);
    checks++; if (obs_err_cyc !== 1) begin errors++; $display("FAIL misalign_short got err cyc %0d want 1", obs_err_cyc); end
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h300, 32'h10, 2'd1, 0, 0, 1'b0, 0, 0, 10);
    checks++; if (obs_vwe_cyc !== 9 || obs_vwd !== model_vector()) begin errors++;
      $display("FAIL after_err_load got cyc %0d vwd %h want cyc 9 vwd %h", obs_vwe_cyc, obs_vwd, model_vector()); end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h1000, 32'h4, 2'd1, 0, 0, 1'b0, 4, 0, 24);
    checks++; if (obs_vwe_cnt !== 1 || obs_addrs.size() !== 4) begin errors++;
      $display("FAIL busy_start got vwe %0d reqs %0d want 1 4", obs_vwe_cnt, obs_addrs.size()); end
    checks++; if (obs_vwa !== 2'd1 || obs_vwd !== model_vector()) begin errors++;
      $display("FAIL busy_start_data got vwa %0d vwd %h want 1 %h", obs_vwa, obs_vwd, model_vector()); end
  endtask

  task automatic test_address_wrap();
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'hFFFF_FFF8, 32'd4, 2'd3, 1, 1, 1'b1, 0, 0, model_cycle(1, 1) + 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a = 32'hFFFF_FFF8 + 32'(i) * 32'd4;
      logic [31:0] got_a = (i < obs_addrs.size()) ? obs_addrs[i] : 32'hxxxx_xxxx;
      checks++; if (got_a !== exp_a) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", i, got_a, exp_a); end
    end
    checks++; if (obs_vwe_cyc !== model_cycle(1, 1)) begin errors++;
      $display("FAIL wrap_vwe_cycle got %0d want %0d", obs_vwe_cyc, model_cycle(1, 1)); end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h2000, 32'h8, 2'd2, 0, 0, 1'b0, 0, 6, 15);
    checks++; if (rst_flags !== 5'b0 || rst_addr !== 32'd0 || rst_vwa !== 2'd0 || rst_vwd !== 128'd0) begin errors++;
      $display("FAIL abort_outputs got flags %b addr %h vwa %0d vwd %h want all 0", rst_flags, rst_addr, rst_vwa, rst_vwd); end
    checks++; if (obs_vwe_cnt !== 0 || obs_busy_cnt !== 5) begin errors++;
      $display("FAIL abort_no_write got vwe %0d busy %0d want 0 5", obs_vwe_cnt, obs_busy_cnt); end
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h3000, 32'h40, 2'd1, 0, 1, 1'b0, 0, 0, model_cycle(0, 1) + 1);
    checks++; if (obs_vwe_cyc !== model_cycle(0, 1) || obs_vwd !== model_vector()) begin errors++;
      $display("FAIL abort_next_load got cyc %0d vwd %h want %0d %h", obs_vwe_cyc, obs_vwd, model_cycle(0, 1), model_vector()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h500, 32'h4, 2'd0, 0, 0, 1'b0, 0, 0, 9);
    checks++; if (obs_vwe_cyc !== 9) begin errors++; $display("FAIL b2b_first got cyc %0d want 9", obs_vwe_cyc); end
    for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
    run_op(32'h600, 32'hC, 2'd3, 0, 0, 1'b0, 0, 0, 10);
    checks++; if (obs_pre_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got %b want 0", obs_pre_busy); end
    checks++; if (obs_vwe_cyc !== 9 || obs_vwa !== 2'd3 || obs_vwd !== model_vector()) begin errors++;
      $display("FAIL b2b_second got cyc %0d vwa %0d vwd %h want 9 3 %h", obs_vwe_cyc, obs_vwa, obs_vwd, model_vector()); end
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] base = $urandom & 32'hFFFF_FFFC;
      logic [31:0] strd = $urandom & 32'h0000_0FFC;
      logic [1:0]  dst  = 2'($urandom_range(0, 3));
      int gd = $urandom_range(0, 3);
      int rd = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) lane_data[i] = $urandom;
      run_op(base, strd, dst, gd, rd, 1'($urandom_range(0, 1)), 0, 0, model_cycle(gd, rd) + 1);
      for (int i = 0; i < 4; i++) begin
        logic [31:0] exp_a = base + 32'(i) * strd;
        logic [31:0] got_a = (i < obs_addrs.size()) ? obs_addrs[i] : 32'hxxxx_xxxx;
        checks++; if (got_a !== exp_a) begin errors++; $display("FAIL rand%0d_addr%0d got %h want %h", k, i, got_a, exp_a); end
      end
      checks++; if (obs_vwe_cyc !== model_cycle(gd, rd) || obs_vwa !== dst) begin errors++;
        $display("FAIL rand%0d_vwe got cyc %0d vwa %0d want %0d %0d", k, obs_vwe_cyc, obs_vwa, model_cycle(gd, rd), dst); end
      checks++; if (obs_vwd !== model_vector() || obs_unstable !== 0 || obs_done_bad !== 0) begin errors++;
        $display("FAIL rand%0d_data got vwd %h unstable %0d done_bad %0d want %h 0 0", k, obs_vwd, obs_unstable, obs_done_bad, model_vector()); end
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_strided_backpressure();
    test_misaligned();
    test_start_while_busy();
    test_address_wrap();
    test_reset_mid_load();
    test_back_to_back();
    test_random_loads();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_load_unit.md
# vector_load_unit

Gathers one V-bit vector from data memory as V/N word reads (base address plus constant byte stride) and writes the assembled vector into the vector register bank in a single write cycle. It sits directly upstream of the vector register bank's vector write port, between the memory data port and the bank. It runs one load at a time, with one outstanding memory request.

## Interface
Parameters:
- V, 128, vector width in bits
- N, 32, element (memory word) width in bits; L = V/N lanes (4 by default)
- AW, 32, byte address width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- base_addr  in  AW  byte address of lane 0
- stride  in  AW  byte distance between consecutive lanes
- dst  in  2  destination vector register index
- busy  out  1  high in ISSUE, WAIT, WRITE
- done  out  1  one-cycle pulse, coincident with vwe
- err  out  1  one-cycle pulse on rejected (misaligned) start
- mem_req  out  1  read request valid
- mem_addr  out  AW  read byte address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  N  read data
- vwe  out  1  vector register write enable, one cycle
- vwa  out  2  vector register write index
- vwd  out  V  vector write data

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, ERR.
- IDLE:
  - start=1 with base_addr[1:0]==0 and stride[1:0]==0: latch base_addr into the address register, latch stride and dst, set lane=0, go to ISSUE.
  - start=1 with either misaligned: go to ERR; no memory request is made.
- ERR: err=1 for one cycle, then IDLE.
- ISSUE: mem_req=1 and mem_addr equals the address register.
  - mem_gnt=1: go to WAIT.
  - Otherwise stay; mem_req and mem_addr are held stable.
- WAIT: mem_req=0.
  - mem_rvalid=1: write mem_rdata into the lane buffer at bits [lane*N +: N], and add stride to the address register (modulo 2^AW, wrap silently).
  - If lane==L-1, go to WRITE; otherwise lane+1 and go to ISSUE.
- WRITE: vwe=1, done=1, vwa equals latched dst, and vwd equals the lane buffer (lane 0 in the LSBs). Next state is IDLE.
- mem_rvalid outside WAIT is ignored. mem_gnt outside ISSUE is ignored.
- start outside IDLE is ignored; it is not queued.
- vwd and vwa are registered and hold their last value after WRITE. The lane buffer is not cleared between loads; every lane is overwritten before each WRITE.
- Reset (rst=0, any state): return to IDLE immediately.
  - Outputs: busy=0, done=0, err=0, mem_req=0, vwe=0.
  - Registers cleared to 0: mem_addr, vwa, vwd, lane buffer, lane counter.
  - An aborted load never produces vwe.

## Timing
- start is sampled at edge 0. mem_req is high from cycle 1.
- Minimum latency (gnt in the first ISSUE cycle, rvalid the cycle after gnt): ISSUE/WAIT alternate over cycles 1-8, WRITE (vwe, done) is in cycle 9, busy falls in cycle 10, and a new start is accepted in cycle 10.
- Each extra cycle of gnt or rvalid delay adds exactly one cycle.
- mem_rvalid must not arrive in the same cycle as its mem_gnt. Earliest valid data is one cycle after the grant.
- Misaligned start at edge 0: err=1 in cycle 1, IDLE in cycle 2, busy never asserted.

## Test plan
- Contiguous load: base=0x100, stride=4, dst=2, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_addr sequence 0x100/0x104/0x108/0x10C; vwe in cycle 9 with vwa=2 and vwd=0x44444444_33333333_22222222_11111111; done in the same cycle.
- Strided load with backpressure: base=0x40, stride=0x20, gnt delayed 2 cycles per request -> addresses 0x40/0x60/0x80/0xA0; mem_addr stable while waiting; vwe in cycle 17.
- Misaligned: base=0x102, stride=4 -> no mem_req, err pulse in cycle 1, busy=0 throughout; and a start with stride=6 behaves the same way.
- Start while busy: second start pulse during WAIT -> ignored; exactly one vwe.
- Address wrap: base=0xFFFFFFF8, stride=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset mid-load: rst low during lane 2 WAIT -> outputs return to reset values immediately, no vwe. The next load completes correctly, with no stale lane data.
